sokoban_game_control: RTL and testbench
=======================================

# sokoban_game_control

Top-level game-flow controller for the Sokoban core, with the 2-bit stage (level) counter built in. It turns mouse and keyboard requests into load, step, undo and retry commands for the external game-state register and step counter. It detects win (all destinations covered by boxes) and lose (step budget exhausted), and advances the stage on request after a win. It sits between the input decoders (mouse/PS2) and the game-state datapath (state register, move logic, undo buffer).

## Interface
Parameters: none; all widths are fixed by the 8×8 board.

- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- game_state  in  134  current board, packed {way[133:70], box[69:6], man[5:0]}; one bit per cell, man is a cell index.
- destination  in  64  target cells of the current stage.
- move_result  in  1  move logic reports that the requested move (toward cursor or key direction) is legal.
- cursor  in  6  mouse cell index; informational, not used internally.
- game_area  in  1  mouse is inside the board area.
- left, right  in  1  mouse buttons (level).
- retry, retract  in  1  on-screen retry/undo buttons (level).
- key_hit, key_retry, key_retract, key_next  in  1  keyboard move, retry, undo and next-stage requests (level).
- real_retract  in  1  undo buffer holds a valid previous state.
- step, step_exp  in  8  steps taken and step budget for the stage.
- stage  out  2  current stage number.
- stage_up  out  1  one-cycle pulse; the stage was incremented.
- game_state_en  out  1  write enable of the external game-state register.
- sel  out  2  state-register source: 0 hold, 1 stage initial map, 2 moved state, 3 undo state.
- win, lose  out  1  level outputs, high while in WIN or LOSE respectively.
- step_inc, step_dec  out  1  one-cycle pulses to the external step counter.

## Operation
Input edges:
- Every request input (left, right, retry, retract, key_*) is registered.
- A request means a rising edge: input high now and low the previous cycle.
- Holding an input high produces exactly one request.

States: INIT, PLAY, WIN, LOSE.

INIT:
- Outputs sel=1, game_state_en=1 for one cycle.
- Next state is PLAY.

PLAY, evaluated in this priority order (highest first):
1. right → stage cleared to 0, go to INIT.
2. retry or key_retry → INIT; the stage is unchanged.
3. retract or key_retract, with real_retract=1 and step≠0 → sel=3, game_state_en=1, step_dec=1.
4. left with game_area=1, or key_hit, with move_result=1 → sel=2, game_state_en=1, step_inc=1. With move_result=0 nothing happens.
5. Otherwise, if destination≠0 and (box & destination)==destination → WIN.
6. Otherwise, if step ≥ step_exp (unsigned) → LOSE.

Win takes precedence over lose when both hold. A destination of 0 never counts as a win.

WIN:
- win=1.
- left or key_next → stage_up=1 for one cycle, stage+1 (wraps 3→0), go to INIT.
- right → stage cleared to 0, go to INIT.
- retry or key_retry → INIT with the same stage.

LOSE:
- lose=1.
- retry or key_retry → INIT.
- right → stage cleared to 0, go to INIT.
- All other requests are ignored.

Stage counter:
- Clears on reset or a right request; clear beats increment.
- Increments on stage_up.

The external step counter is cleared by the integrator on reset, right, retry/key_retry and stage_up. This block never clears it.

## Timing
- All outputs are registered. The response appears in the cycle after the edge that samples the request rising.
- game_state_en, step_inc, step_dec and stage_up are single-cycle pulses.
- sel is 0 whenever game_state_en=0.
- Win and lose are evaluated every PLAY cycle with no request. They are entered one cycle after the condition becomes true.
- While reset is high, all outputs are 0 and the state is INIT. On the first cycle after reset is released, sel=1 and game_state_en=1.
- A reset asserted in the middle of any operation aborts it in that cycle; no pending pulse is emitted.
- Simultaneous requests resolve by the priority above. Only one action happens per cycle.

## Test plan
- Reset held for 3 cycles, then released with box=1, destination=2 → stage=0, one INIT pulse (sel=1, en=1), then PLAY with win=0 and lose=0.
- right held for 3 cycles → stage=0, one INIT pulse only.
- left=1 with game_area=1, move_result=1 → single pulse of step_inc=1, sel=2, en=1. Same stimulus with move_result=0 → no pulse.
- retract with real_retract=1, step=3 → step_dec=1, sel=3. Retry → INIT pulse, stage unchanged.
- destination changed to 1 while box=1 → win=1. Next left rising edge → stage_up pulse, stage 0→1, INIT. From stage 3 the same sequence wraps stage to 0.
- destination=0, step=255, step_exp=250 → lose=1 with win=0. key_retry → INIT and lose=0.

Source files
------------

// File: rtl/sokoban_game_control_if.sv
// ============================================================================
// Module      : sokoban_game_control_if
// Description : Request/command bundle between the input decoders, the
//               game-state datapath and the Sokoban game-flow controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sokoban_game_control_if;
    logic [133:0] game_state;
    logic [63:0]  destination;
    logic         move_result;
    logic [5:0]   cursor;
    logic         game_area;
    logic         left;
    logic         right;
    logic         retry;
    logic         retract;
    logic         key_hit;
    logic         key_retry;
    logic         key_retract;
    logic         key_next;
    logic         real_retract;
    logic [7:0]   step;
    logic [7:0]   step_exp;
    logic [1:0]   stage;
    logic         stage_up;
    logic         game_state_en;
    logic [1:0]   sel;
    logic         win;
    logic         lose;
    logic         step_inc;
    logic         step_dec;

    // Requester / datapath side
    modport master (
        output game_state, destination, move_result, cursor, game_area,
               left, right, retry, retract, key_hit, key_retry, key_retract,
               key_next, real_retract, step, step_exp,
        input  stage, stage_up, game_state_en, sel, win, lose, step_inc, step_dec
    );

    // Controller side
    modport slave (
        input  game_state, destination, move_result, cursor, game_area,
               left, right, retry, retract, key_hit, key_retry, key_retract,
               key_next, real_retract, step, step_exp,
        output stage, stage_up, game_state_en, sel, win, lose, step_inc, step_dec
    );
endinterface

`default_nettype wire

// File: rtl/sokoban_game_control.sv
// ============================================================================
// Module      : sokoban_game_control
// Description : Sokoban game-flow FSM (INIT/PLAY/WIN/LOSE) with stage counter;
//               turns edge-detected requests into state-register commands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sokoban_game_control (
    input  wire                    clk,
    input  wire                    reset,
    sokoban_game_control_if.slave  bus
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    localparam logic [1:0] c_SEL_HOLD = 2'd0;
    localparam logic [1:0] c_SEL_INIT = 2'd1;
    localparam logic [1:0] c_SEL_MOVE = 2'd2;
    localparam logic [1:0] c_SEL_UNDO = 2'd3;

    state_t     r_state;
    state_t     w_state_d;
    logic [7:0] r_req_q;
    logic [7:0] w_req_now;
    logic [7:0] w_rise;
    logic [1:0] r_stage;
    logic [1:0] r_sel;
    logic       r_en;
    logic       r_inc;
    logic       r_dec;
    logic       r_up;
    logic       r_win;
    logic       r_lose;
    logic [1:0] w_sel_d;
    logic       w_en_d;
    logic       w_inc_d;
    logic       w_dec_d;
    logic       w_up_d;
    logic       w_clr;
    logic       w_right_req;
    logic       w_retry_req;
    logic       w_undo_req;
    logic       w_move_req;
    logic       w_next_req;
    logic       w_all_covered;
    logic [63:0] w_box;
    logic       w_unused;

    assign w_req_now = {bus.left, bus.right, bus.retry, bus.retract,
                        bus.key_hit, bus.key_retry, bus.key_retract, bus.key_next};
    assign w_rise    = w_req_now & ~r_req_q;

    assign w_right_req = w_rise[6];
    assign w_retry_req = w_rise[5] | w_rise[2];
    assign w_undo_req  = w_rise[4] | w_rise[1];
    assign w_move_req  = (w_rise[7] & bus.game_area) | w_rise[3];
    assign w_next_req  = w_rise[7] | w_rise[0];

    // An empty destination set must never count as a solved board
    assign w_box         = bus.game_state[69:6];
    assign w_all_covered = (bus.destination != 64'd0) &&
                           ((w_box & bus.destination) == bus.destination);

    assign w_unused = ^{bus.cursor, bus.game_state[133:70], bus.game_state[5:0]};

    always_comb begin
        w_state_d = r_state;
        w_sel_d   = c_SEL_HOLD;
        w_en_d    = 1'b0;
        w_inc_d   = 1'b0;
        w_dec_d   = 1'b0;
        w_up_d    = 1'b0;
        w_clr     = 1'b0;
        case (r_state)
            S_INIT: begin
                w_sel_d   = c_SEL_INIT;
                w_en_d    = 1'b1;
                w_state_d = S_PLAY;
            end
            S_PLAY: begin
                if (w_right_req) begin
                    w_clr     = 1'b1;
                    w_state_d = S_INIT;
                end else if (w_retry_req) begin
                    w_state_d = S_INIT;
                end else if (w_undo_req && bus.real_retract && (bus.step != 8'd0)) begin
                    w_sel_d = c_SEL_UNDO;
                    w_en_d  = 1'b1;
                    w_dec_d = 1'b1;
                end else if (w_move_req) begin
                    // An illegal move consumes the request without effect
                    if (bus.move_result) begin
                        w_sel_d = c_SEL_MOVE;
                        w_en_d  = 1'b1;
                        w_inc_d = 1'b1;
                    end
                end else if (w_all_covered) begin
                    w_state_d = S_WIN;
                end else if (bus.step >= bus.step_exp) begin
                    w_state_d = S_LOSE;
                end
            end
            S_WIN: begin
                if (w_right_req) begin
                    w_clr     = 1'b1;
                    w_state_d = S_INIT;
                end else if (w_next_req) begin
                    w_up_d    = 1'b1;
                    w_state_d = S_INIT;
                end else if (w_retry_req) begin
                    w_state_d = S_INIT;
                end
            end
            S_LOSE: begin
                if (w_right_req) begin
                    w_clr     = 1'b1;
                    w_state_d = S_INIT;
                end else if (w_retry_req) begin
                    w_state_d = S_INIT;
                end
            end
            default: w_state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
            r_req_q <= 8'd0;
            r_stage <= 2'd0;
            r_sel   <= c_SEL_HOLD;
            r_en    <= 1'b0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_up    <= 1'b0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_req_q <= w_req_now;
            if (w_clr) begin
                r_stage <= 2'd0;
            end else if (w_up_d) begin
                r_stage <= r_stage + 2'd1;
            end
            r_sel   <= w_sel_d;
            r_en    <= w_en_d;
            r_inc   <= w_inc_d;
            r_dec   <= w_dec_d;
            r_up    <= w_up_d;
            r_win   <= (w_state_d == S_WIN);
            r_lose  <= (w_state_d == S_LOSE);
        end
    end

    assign bus.stage         = r_stage;
    assign bus.stage_up      = r_up;
    assign bus.game_state_en = r_en;
    assign bus.sel           = r_sel;
    assign bus.win           = r_win;
    assign bus.lose          = r_lose;
    assign bus.step_inc      = r_inc;
    assign bus.step_dec      = r_dec;

endmodule

`default_nettype wire

// File: tb/tb_sokoban_game_control.sv
// ============================================================================
// Module      : tb_sokoban_game_control
// Description : Table-driven self-checking bench for sokoban_game_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sokoban_game_control;

    localparam logic [7:0] R_LEFT     = 8'h80;
    localparam logic [7:0] R_RIGHT    = 8'h40;
    localparam logic [7:0] R_RETRY    = 8'h20;
    localparam logic [7:0] R_RETRACT  = 8'h10;
    localparam logic [7:0] R_KHIT     = 8'h08;
    localparam logic [7:0] R_KRETRY   = 8'h04;
    localparam logic [7:0] R_KNEXT    = 8'h01;
    localparam logic [2:0] C_AREA     = 3'b100;
    localparam logic [2:0] C_MOVE     = 3'b010;
    localparam logic [2:0] C_REAL     = 3'b001;

    typedef struct {
        logic [7:0]  req;
        logic [2:0]  ctl;
        logic [7:0]  step;
        logic [7:0]  step_exp;
        logic [63:0] box;
        logic [63:0] dest;
        logic [9:0]  exp;   // {stage, sel, en, inc, dec, up, win, lose}
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sokoban_game_control_if bus();

    sokoban_game_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(logic [7:0] req, logic [2:0] ctl, logic [7:0] step,
                                logic [7:0] step_exp, logic [63:0] box,
                                logic [63:0] dest, logic [9:0] exp);
        vec_t v;
        v.req = req; v.ctl = ctl; v.step = step; v.step_exp = step_exp;
        v.box = box; v.dest = dest; v.exp = exp;
        return v;
    endfunction

    task automatic apply(vec_t v);
        {bus.left, bus.right, bus.retry, bus.retract,
         bus.key_hit, bus.key_retry, bus.key_retract, bus.key_next} = v.req;
        {bus.game_area, bus.move_result, bus.real_retract} = v.ctl;
        bus.step        = v.step;
        bus.step_exp    = v.step_exp;
        bus.game_state  = {64'd0, v.box, 6'd0};
        bus.destination = v.dest;
        bus.cursor      = 6'd0;
    endtask

    task automatic check(string name, logic [9:0] exp);
        logic [9:0] got;
        got = {bus.stage, bus.sel, bus.game_state_en, bus.step_inc,
               bus.step_dec, bus.stage_up, bus.win, bus.lose};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b (stage,sel,en,inc,dec,up,win,lose)",
                     name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-by-cycle script; each entry is applied before one clock edge
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(R_RIGHT, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(R_RIGHT, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_01_100000));
        vecs.push_back(mk(R_RIGHT, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(R_LEFT, C_AREA | C_MOVE, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_10_110000));
        vecs.push_back(mk(R_LEFT, C_AREA | C_MOVE, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, C_AREA | C_MOVE, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(R_LEFT, C_AREA, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(R_KHIT, C_MOVE, 8'd1, 8'd10, 64'd1, 64'd2, 10'b00_10_110000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd1, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(R_RETRACT, C_REAL, 8'd3, 8'd10, 64'd1, 64'd2, 10'b00_11_101000));
        vecs.push_back(mk(8'h00, C_REAL, 8'd2, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(R_RETRACT, 3'b000, 8'd2, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd2, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(R_RETRY, 3'b000, 8'd2, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        // Win and stage advance through all four stages with wrap
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b00_00_000010));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b00_00_000010));
        vecs.push_back(mk(R_LEFT, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b01_00_000100));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b01_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b01_00_000010));
        vecs.push_back(mk(R_KNEXT, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b10_00_000100));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b10_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b10_00_000010));
        vecs.push_back(mk(R_LEFT, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b11_00_000100));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b11_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b11_00_000010));
        vecs.push_back(mk(R_LEFT, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b00_00_000100));
        // Lose with empty destination, requests ignored, key_retry recovers
        vecs.push_back(mk(8'h00, 3'b000, 8'd255, 8'd250, 64'd1, 64'd0, 10'b00_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd255, 8'd250, 64'd1, 64'd0, 10'b00_00_000001));
        vecs.push_back(mk(R_LEFT, C_AREA | C_MOVE, 8'd255, 8'd250, 64'd1, 64'd0, 10'b00_00_000001));
        vecs.push_back(mk(8'h00, 3'b000, 8'd255, 8'd250, 64'd1, 64'd0, 10'b00_00_000001));
        vecs.push_back(mk(R_KRETRY, 3'b000, 8'd255, 8'd250, 64'd1, 64'd0, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd250, 64'd1, 64'd0, 10'b00_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd250, 64'd1, 64'd0, 10'b00_00_000000));
        // Win beats lose; retry from WIN keeps the stage
        vecs.push_back(mk(8'h00, 3'b000, 8'd255, 8'd250, 64'd1, 64'd1, 10'b00_00_000010));
        vecs.push_back(mk(R_RETRY, 3'b000, 8'd255, 8'd250, 64'd1, 64'd1, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_01_100000));
        // Undo beats move when both arrive together
        vecs.push_back(mk(R_RETRACT | R_LEFT, C_AREA | C_MOVE | C_REAL, 8'd3, 8'd10, 64'd1, 64'd2, 10'b00_11_101000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd2, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        // Right beats retry and clears a non-zero stage
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b00_00_000010));
        vecs.push_back(mk(R_KNEXT, 3'b000, 8'd0, 8'd10, 64'd1, 64'd1, 10'b01_00_000100));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b01_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b01_00_000000));
        vecs.push_back(mk(R_RIGHT | R_RETRY, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        // step == step_exp is already a loss; one below is not
        vecs.push_back(mk(8'h00, 3'b000, 8'd10, 8'd10, 64'd1, 64'd2, 10'b00_00_000001));
        vecs.push_back(mk(R_RETRY, 3'b000, 8'd10, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'b00_01_100000));
        vecs.push_back(mk(8'h00, 3'b000, 8'd9, 8'd10, 64'd1, 64'd2, 10'b00_00_000000));

        reset = 1'b1;
        apply(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'd0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset%0d", i), 10'b00_00_000000);
        end
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset arriving together with a move request suppresses the pulse
        apply(mk(R_LEFT, C_AREA | C_MOVE, 8'd0, 8'd10, 64'd1, 64'd2, 10'd0));
        reset = 1'b1;
        tick();
        check("reset_abort", 10'b00_00_000000);
        reset = 1'b0;
        apply(mk(8'h00, 3'b000, 8'd0, 8'd10, 64'd1, 64'd2, 10'd0));
        tick();
        check("post_reset_init", 10'b00_01_100000);
        tick();
        check("post_reset_play", 10'b00_00_000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
